// File: rtl/csr_int_unit.sv
// csr_int_unit: machine-mode interrupt CSRs (mstatus, mie, mtvec, mepc, mcause)
// with a synchronised external interrupt request and trap/MRET sequencing.
module csr_int_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        int_req,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wd,
    input  logic [31:0] pc,
    input  logic        int_ack,
    input  logic        mret_exec,
    output logic        int_taken_req,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic [31:0] csr_rd
);
    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    logic        s1, s2, s3, pend, rise, trap;
    logic        mie_bit, mpie_bit, meie_bit;
    logic [31:0] mcause;
    assign rise          = s2 & ~s3;
    assign int_taken_req = pend & mie_bit & meie_bit;
    assign trap          = int_ack & int_taken_req;
    always_comb begin
        csr_rd = (csr_addr == A_MSTATUS) ? {24'b0, mpie_bit, 3'b0, mie_bit, 3'b0} :
                 (csr_addr == A_MIE)     ? {20'b0, meie_bit, 11'b0} :
                 (csr_addr == A_MTVEC)   ? mtvec :
                 (csr_addr == A_MEPC)    ? mepc :
                 (csr_addr == A_MCAUSE)  ? mcause : 32'b0;
    end
    // Trap entry beats MRET beats CSR write; losers are dropped for the cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            pend     <= 1'b0;
            mie_bit  <= 1'b0;
            mpie_bit <= 1'b0;
            meie_bit <= 1'b0;
            mtvec    <= 32'b0;
            mepc     <= 32'b0;
            mcause   <= 32'b0;
        end else begin
            s1   <= int_req;
            s2   <= s1;
            s3   <= s2;
            pend <= rise | (pend & ~trap);
            if (trap) begin
                mepc     <= {pc[31:2], 2'b00};
                mpie_bit <= mie_bit;
                mie_bit  <= 1'b0;
                mcause   <= 32'h8000_000B;
            end else if (mret_exec) begin
                mie_bit  <= mpie_bit;
                mpie_bit <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    A_MSTATUS: begin
                        mie_bit  <= csr_wd[3];
                        mpie_bit <= csr_wd[7];
                    end
                    A_MIE:   meie_bit <= csr_wd[11];
                    A_MTVEC: mtvec    <= {csr_wd[31:2], 2'b00};
                    A_MEPC:  mepc     <= {csr_wd[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/csr_int_unit.md
CSR_INT_UNIT -- requirements
Module: csr_int_unit

Interface
REQ-001 The clock and reset ports SHALL be: CLK  in  1  system clock, rising-edge; RST  in  1  synchronous active-high reset.
REQ-002 int_req  in  1  SHALL be the external interrupt request: asynchronous to CLK, level, rising edge significant.
REQ-003 csr_we  in  1  SHALL be the CSR write strobe, one cycle per instruction.
REQ-004 csr_addr  in  12  SHALL be the CSR address taken from instruction bits [31:20].
REQ-005 csr_wd  in  32  SHALL be the CSR write data, taken from the ALU result.
REQ-006 pc  in  32  SHALL be the PC of the instruction being interrupted.
REQ-007 int_ack  in  1  SHALL be asserted by the control FSM for one cycle at trap entry.
REQ-008 mret_exec  in  1  SHALL be asserted by the control FSM for one cycle when MRET retires.
REQ-009 int_taken_req  out  1  SHALL be the trap request to the control FSM.
REQ-010 mtvec  out  32  SHALL be the trap vector; mepc  out  32  SHALL be the MRET return address.
REQ-011 csr_rd  out  32  SHALL be the combinational read data for csr_addr.

Function
REQ-012 Implemented CSRs SHALL be: mstatus 0x300 (bit3 MIE, bit7 MPIE); mie 0x304 (bit11 MEIE); mtvec 0x305; mepc 0x341; mcause 0x342.
- Unimplemented mstatus/mie bits: read 0, writes ignored.
REQ-013 mtvec and mepc writes SHALL force bits [1:0] to 0 (direct mode, word-aligned).
REQ-014 mcause SHALL be read-only; writes to it are ignored.
REQ-015 Reads of unmapped addresses SHALL return 0; writes to unmapped addresses SHALL have no effect.
REQ-016 int_req SHALL pass through a two-flop synchronizer (s1, s2) and a third flop s3 for edge detection.
- Rising edge detected when s2=1 and s3=0.
REQ-017 A detected rising edge SHALL set the pend flag on the next CLK edge.
- Latency: int_req rising before edge N gives pend=1 after edge N+2.
- Further edges while pend=1 SHALL collapse into a single pending interrupt.
REQ-018 int_taken_req SHALL equal pend AND MIE AND MEIE (combinational).
REQ-019 int_ack with int_taken_req=1 SHALL perform trap entry, all updates on the same edge:
- mepc<=pc with [1:0] forced to 0;
- MPIE<=MIE; MIE<=0;
- mcause<=0x8000000B;
- pend<=0, unless a new edge is detected in the same cycle, in which case pend stays 1.
REQ-020 int_ack with int_taken_req=0 SHALL be ignored.
REQ-021 mret_exec SHALL set MIE<=MPIE and MPIE<=1.
REQ-022 Priority on the same cycle SHALL be int_ack (honored) > mret_exec > csr_we.
- The lower-priority events are discarded entirely for that cycle.
REQ-023 A CSR write that sets MIE while pend=1 and MEIE=1 SHALL assert int_taken_req on the cycle after the write.
REQ-024 All state SHALL change only on rising CLK edges; csr_rd SHALL reflect the current register values (no write-to-read bypass).

Reset
REQ-025 On RST=1 at a CLK edge the following SHALL clear to 0: mstatus, mie, mtvec, mepc, mcause, pend, s1, s2, s3.
- Outputs after reset: int_taken_req=0, mtvec=0, mepc=0.
REQ-026 RST SHALL override all other inputs in the cycle it is asserted.
REQ-027 An int_req held high across reset release SHALL be detected as a new edge; pend=1 3 cycles after RST deasserts.
REQ-028 Reset mid-trap SHALL discard any pending interrupt and any partial CSR update.

Verification
REQ-029 Write/read test: write 0x00001003 to mtvec -> csr_rd=0x00001000 and mtvec=0x00001000.
- Write 0xFFFFFFFF to mstatus -> csr_rd=0x00000088.
REQ-030 Trap entry test: MIE=1, MEIE=1, pc=0x0000_0124; pulse int_req -> int_taken_req=1 at edge N+2.
- Then int_ack -> mepc=0x124, mcause=0x8000000B, mstatus=0x80, int_taken_req=0.
REQ-031 MRET test: from the post-trap state, pulse mret_exec -> mstatus=0x88.
- With a new int_req edge, int_taken_req re-asserts.
REQ-032 Masked-pending test: MIE=0; pulse int_req three times -> pend=1 and int_taken_req=0.
- Write mstatus=0x8 -> int_taken_req=1 the next cycle; one int_ack -> int_taken_req=0.
REQ-033 Collision test: int_ack, mret_exec and csr_we (mepc=0x200) in the same cycle -> trap-entry values only; mepc=pc.
REQ-034 Reset test: assert RST during pend=1 with int_req held high -> all CSRs=0.
- pend re-sets 3 cycles after RST deasserts.
